// File: rtl/rv32_muldiv_pkg.sv
// Shared op encodings, FSM state type and helpers for the RV32M execute unit.
package rv32_muldiv_pkg;

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  function automatic logic is_signed_div(input logic [2:0] op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/rv32_divider_step.sv
// Combinational restoring shift-subtract: resolves DIV_BITS quotient bits of
// an unsigned division per call.
module rv32_divider_step #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor_in,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  always_comb begin
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] q;
    r     = rem_in;
    q     = quo_in;
    trial = '0;
    // quo holds the unconsumed dividend bits on top and the quotient below
    for (int i = 0; i < DIV_BITS; i++) begin
      trial = {r, q[XLEN-1]};
      q     = {q[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, divisor_in}) begin
        trial = trial - {1'b0, divisor_in};
        q[0]  = 1'b1;
      end
      r = trial[XLEN-1:0];
    end
    rem_out = r;
    quo_out = q;
  end

endmodule

// File: rtl/rv32_muldiv_execute.sv
// RV32M execute stage: operand forwarding, single-cycle multiply, iterative
// restoring divide and the execute/memory pipeline register.
module rv32_muldiv_execute
  import rv32_muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_BYPASS = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall_in,
  input  logic                       flush_in,
  input  logic                       valid_in,
  input  logic                       muldiv_in,
  input  logic [2:0]                 op_in,
  input  logic [4:0]                 rs1_in,
  input  logic [4:0]                 rs2_in,
  input  logic [XLEN-1:0]            rs1_value_in,
  input  logic [XLEN-1:0]            rs2_value_in,
  input  logic [4:0]                 rd_in,
  input  logic                       rd_write_in,
  input  logic [NUM_BYPASS*5-1:0]    bypass_rd_in,
  input  logic [NUM_BYPASS-1:0]      bypass_write_in,
  input  logic [NUM_BYPASS-1:0]      bypass_flush_in,
  input  logic [NUM_BYPASS*XLEN-1:0] bypass_value_in,
  output logic                       busy_out,
  output logic                       valid_out,
  output logic [4:0]                 rd_out,
  output logic                       rd_write_out,
  output logic [XLEN-1:0]            result_out
);

  localparam int N  = XLEN / DIV_BITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic            start, complete, step;

  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [4:0]      rd_q;
  logic            rd_write_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN-1:0] rem_next, quo_next;
  logic [XLEN-1:0] result_c;

  // Lowest index wins, so walk from the top down and let later hits overwrite.
  always_comb begin
    op_a = rs1_value_in;
    op_b = rs2_value_in;
    for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
      if (bypass_write_in[i] && !bypass_flush_in[i]) begin
        if (rs1_in != 5'd0 && bypass_rd_in[i*5 +: 5] == rs1_in)
          op_a = bypass_value_in[i*XLEN +: XLEN];
        if (rs2_in != 5'd0 && bypass_rd_in[i*5 +: 5] == rs2_in)
          op_b = bypass_value_in[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    mag_a = (is_signed_div(op_in) && op_a[XLEN-1]) ? -op_a : op_a;
    mag_b = (is_signed_div(op_in) && op_b[XLEN-1]) ? -op_b : op_b;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start)    state_next = EXEC;
      EXEC: if (complete) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
    if (flush_in) state_next = IDLE;
  end

  always_comb begin
    start    = (state == IDLE) && valid_in && muldiv_in && !flush_in && !stall_in;
    complete = (state == EXEC) && (count == '0) && !stall_in && !flush_in;
    step     = (state == EXEC) && (count != '0) && !stall_in && !flush_in;
    busy_out = start || ((state == EXEC) && (count != '0));
  end

  rv32_divider_step #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_step (
    .rem_in     (rem_q),
    .quo_in     (quo_q),
    .divisor_in (dvs_q),
    .rem_out    (rem_next),
    .quo_out    (quo_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      op_q       <= MUL;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      rd_write_q <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
    end else if (start) begin
      count      <= is_div_op(op_in) ? CW'(N) : '0;
      op_q       <= op_in;
      a_q        <= op_a;
      b_q        <= op_b;
      rd_q       <= rd_in;
      rd_write_q <= rd_write_in;
      rem_q      <= '0;
      quo_q      <= mag_a;
      dvs_q      <= mag_b;
    end else if (flush_in) begin
      count <= '0;
    end else if (step) begin
      count <= count - 1'b1;
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

  // Product and sign correction are only consumed in the completion cycle.
  always_comb begin
    logic            a_sign, b_sign, neg_q, neg_r;
    logic [2*XLEN-1:0] a_wide, b_wide, product;
    logic [XLEN-1:0] q_res, r_res;
    a_sign  = (op_q == MUL) || (op_q == MULH) || (op_q == MULHSU);
    b_sign  = (op_q == MUL) || (op_q == MULH);
    a_wide  = {{XLEN{a_sign & a_q[XLEN-1]}}, a_q};
    b_wide  = {{XLEN{b_sign & b_q[XLEN-1]}}, b_q};
    product = a_wide * b_wide;

    neg_q = is_signed_div(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    neg_r = is_signed_div(op_q) && a_q[XLEN-1];
    q_res = neg_q ? -quo_q : quo_q;
    r_res = neg_r ? -rem_q : rem_q;
    if (b_q == '0) begin
      q_res = '1;
      r_res = a_q;
    end else if (is_signed_div(op_q) && a_q == XMIN && b_q == '1) begin
      q_res = XMIN;
      r_res = '0;
    end

    result_c = '0;
    case (op_q)
      MUL:                 result_c = product[XLEN-1:0];
      MULH, MULHSU, MULHU: result_c = product[2*XLEN-1:XLEN];
      DIV, DIVU:           result_c = q_res;
      REM, REMU:           result_c = r_res;
      default:             result_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out    <= 1'b0;
      rd_out       <= '0;
      rd_write_out <= 1'b0;
      result_out   <= '0;
    end else if (!stall_in) begin
      if (complete) begin
        valid_out    <= 1'b1;
        rd_out       <= rd_q;
        rd_write_out <= rd_write_q;
        result_out   <= result_c;
      end else begin
        valid_out    <= 1'b0;
        rd_write_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_muldiv_execute.sv
// Directed bench for rv32_muldiv_execute with hand-computed RV32M results.
module tb_rv32_muldiv_execute;
  import rv32_muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int NB   = 2;

  logic            clk = 1'b0;
  logic            reset, stall_in, flush_in, valid_in, muldiv_in;
  logic [2:0]      op_in;
  logic [4:0]      rs1_in, rs2_in, rd_in;
  logic [XLEN-1:0] rs1_value_in, rs2_value_in;
  logic            rd_write_in;
  logic [NB*5-1:0]    bypass_rd_in;
  logic [NB-1:0]      bypass_write_in, bypass_flush_in;
  logic [NB*XLEN-1:0] bypass_value_in;
  logic            busy_out, valid_out, rd_write_out;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rv32_muldiv_execute #(.XLEN(XLEN), .NUM_BYPASS(NB), .DIV_BITS(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_in        (stall_in),
    .flush_in        (flush_in),
    .valid_in        (valid_in),
    .muldiv_in       (muldiv_in),
    .op_in           (op_in),
    .rs1_in          (rs1_in),
    .rs2_in          (rs2_in),
    .rs1_value_in    (rs1_value_in),
    .rs2_value_in    (rs2_value_in),
    .rd_in           (rd_in),
    .rd_write_in     (rd_write_in),
    .bypass_rd_in    (bypass_rd_in),
    .bypass_write_in (bypass_write_in),
    .bypass_flush_in (bypass_flush_in),
    .bypass_value_in (bypass_value_in),
    .busy_out        (busy_out),
    .valid_out       (valid_out),
    .rd_out          (rd_out),
    .rd_write_out    (rd_write_out),
    .result_out      (result_out)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op; lat counts cycles from accept to valid_out (-1 if none).
  task automatic do_op(input logic [2:0] op, input logic [4:0] rs1,
                       input logic [31:0] a, input logic [31:0] b,
                       input int stall_at, input int stall_len, input int flush_at,
                       output logic [31:0] res, output int lat, output int busy_cycles);
    @(negedge clk);
    valid_in = 1'b1; muldiv_in = 1'b1; op_in = op;
    rs1_in = rs1; rs2_in = 5'd2; rs1_value_in = a; rs2_value_in = b;
    rd_in = 5'd9; rd_write_in = 1'b1;
    res = '0; lat = -1; busy_cycles = 0;
    #1;
    if (busy_out === 1'b1) busy_cycles++;
    @(posedge clk); #1;
    valid_in = 1'b0; muldiv_in = 1'b0;
    rs1_value_in = 32'hDEAD_BEEF; rs2_value_in = 32'hDEAD_BEEF;
    bypass_write_in = '0;
    for (int k = 1; k <= 60; k++) begin
      if (k == stall_at) stall_in = 1'b1;
      if (k == stall_at + stall_len) stall_in = 1'b0;
      if (k == flush_at) flush_in = 1'b1;
      if (k == flush_at + 1) flush_in = 1'b0;
      #1;
      if (busy_out === 1'b1) busy_cycles++;
      if (valid_out === 1'b1) begin
        lat = k;
        res = result_out;
        break;
      end
      @(posedge clk); #1;
    end
    stall_in = 1'b0; flush_in = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    int lat, busy_cycles, hits;

    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0; muldiv_in = 1'b0;
    op_in = MUL; rs1_in = '0; rs2_in = '0; rs1_value_in = '0; rs2_value_in = '0;
    rd_in = '0; rd_write_in = 1'b0;
    bypass_rd_in = '0; bypass_write_in = '0; bypass_flush_in = '0; bypass_value_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_valid", 32'(valid_out), 32'd0);
    check32("reset_rd_write", 32'(rd_write_out), 32'd0);
    check32("reset_rd", 32'(rd_out), 32'd0);
    check32("reset_result", result_out, 32'd0);
    check32("reset_busy", 32'(busy_out), 32'd0);
    @(negedge clk); reset = 1'b0;

    do_op(MUL, 5'd1, 32'd7, -32'sd3, 0, 0, 0, res, lat, busy_cycles);
    check32("mul_result", res, 32'hFFFF_FFEB);
    check32("mul_latency", 32'(lat), 32'd2);
    check32("mul_busy", 32'(busy_cycles), 32'd1);
    check32("mul_rd", 32'(rd_out), 32'd9);
    check32("mul_rd_write", 32'(rd_write_out), 32'd1);
    @(posedge clk); #1;
    check32("mul_valid_pulse", 32'(valid_out), 32'd0);

    do_op(MULH, 5'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, res, lat, busy_cycles);
    check32("mulh_result", res, 32'h4000_0000);
    do_op(MULHSU, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, res, lat, busy_cycles);
    check32("mulhsu_result", res, 32'hFFFF_FFFF);
    do_op(MULHU, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, res, lat, busy_cycles);
    check32("mulhu_result", res, 32'hFFFF_FFFE);

    do_op(DIV, 5'd1, -32'sd20, 32'd3, 0, 0, 0, res, lat, busy_cycles);
    check32("div_result", res, 32'hFFFF_FFFA);
    check32("div_latency", 32'(lat), 32'd34);
    check32("div_busy", 32'(busy_cycles), 32'd33);
    do_op(REM, 5'd1, -32'sd20, 32'd3, 0, 0, 0, res, lat, busy_cycles);
    check32("rem_result", res, 32'hFFFF_FFFE);
    do_op(DIV, 5'd1, 32'd20, -32'sd3, 0, 0, 0, res, lat, busy_cycles);
    check32("div_pos_neg", res, 32'hFFFF_FFFA);
    do_op(REM, 5'd1, 32'd20, -32'sd3, 0, 0, 0, res, lat, busy_cycles);
    check32("rem_pos_neg", res, 32'd2);
    do_op(DIVU, 5'd1, 32'd100, 32'd7, 0, 0, 0, res, lat, busy_cycles);
    check32("divu_result", res, 32'd14);
    do_op(REMU, 5'd1, 32'd100, 32'd7, 0, 0, 0, res, lat, busy_cycles);
    check32("remu_result", res, 32'd2);

    do_op(DIVU, 5'd1, 32'd5, 32'd0, 0, 0, 0, res, lat, busy_cycles);
    check32("divu_by_zero", res, 32'hFFFF_FFFF);
    check32("divu_by_zero_latency", 32'(lat), 32'd34);
    do_op(REM, 5'd1, 32'd5, 32'd0, 0, 0, 0, res, lat, busy_cycles);
    check32("rem_by_zero", res, 32'd5);
    do_op(DIV, 5'd1, -32'sd20, 32'd0, 0, 0, 0, res, lat, busy_cycles);
    check32("div_neg_by_zero", res, 32'hFFFF_FFFF);
    do_op(REM, 5'd1, -32'sd20, 32'd0, 0, 0, 0, res, lat, busy_cycles);
    check32("rem_neg_by_zero", res, 32'hFFFF_FFEC);
    do_op(DIV, 5'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, res, lat, busy_cycles);
    check32("div_overflow", res, 32'h8000_0000);
    do_op(REM, 5'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, res, lat, busy_cycles);
    check32("rem_overflow", res, 32'd0);

    bypass_rd_in = {5'd5, 5'd5}; bypass_value_in = {32'd22, 32'd11};
    bypass_write_in = 2'b11; bypass_flush_in = 2'b00;
    do_op(MUL, 5'd5, 32'd99, 32'd1, 0, 0, 0, res, lat, busy_cycles);
    check32("bypass_priority", res, 32'd11);
    bypass_write_in = 2'b11; bypass_flush_in = 2'b01;
    do_op(MUL, 5'd5, 32'd99, 32'd1, 0, 0, 0, res, lat, busy_cycles);
    check32("bypass_flushed_src", res, 32'd22);
    bypass_rd_in = {5'd0, 5'd0}; bypass_write_in = 2'b11; bypass_flush_in = 2'b00;
    do_op(MUL, 5'd0, 32'd0, 32'd1, 0, 0, 0, res, lat, busy_cycles);
    check32("bypass_x0", res, 32'd0);
    bypass_flush_in = 2'b00;

    do_op(MUL, 5'd1, 32'd6, 32'd7, 1, 2, 0, res, lat, busy_cycles);
    check32("mul_stall_result", res, 32'd42);
    check32("mul_stall_latency", 32'(lat), 32'd4);
    check32("mul_stall_busy", 32'(busy_cycles), 32'd1);

    do_op(DIV, 5'd1, -32'sd20, 32'd3, 10, 3, 0, res, lat, busy_cycles);
    check32("div_stall_result", res, 32'hFFFF_FFFA);
    check32("div_stall_latency", 32'(lat), 32'd37);

    do_op(DIV, 5'd1, 32'd100, 32'd7, 0, 0, 5, res, lat, busy_cycles);
    check32("div_flush_no_result", 32'(lat), 32'hFFFF_FFFF);
    check32("div_flush_busy", 32'(busy_out), 32'd0);
    check32("div_flush_valid", 32'(valid_out), 32'd0);

    @(negedge clk);
    valid_in = 1'b1; muldiv_in = 1'b1; op_in = DIV; rs1_in = 5'd1; rs2_in = 5'd2;
    rs1_value_in = 32'd100; rs2_value_in = 32'd7; rd_in = 5'd9; rd_write_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; muldiv_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check32("mid_div_busy", 32'(busy_out), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check32("rst_mid_valid", 32'(valid_out), 32'd0);
    check32("rst_mid_rd_write", 32'(rd_write_out), 32'd0);
    check32("rst_mid_rd", 32'(rd_out), 32'd0);
    check32("rst_mid_result", result_out, 32'd0);
    check32("rst_mid_busy", 32'(busy_out), 32'd0);
    reset = 1'b0;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (valid_out === 1'b1 || busy_out === 1'b1) hits++;
    end
    check32("rst_mid_quiet", 32'(hits), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rv32_muldiv_execute.md
# rv32_muldiv_execute

Parametrised execute-stage unit for the RV32M extension, sitting beside the ALU path between decode and memory. It forwards operands from a configurable number of bypass sources and runs a single-cycle multiplier and an iterative divider producing DIV_BITS quotient bits per cycle. It registers its result into an execute/memory pipeline register with stall and flush semantics. While an operation is in flight it raises `busy_out` so the hazard unit can freeze upstream stages.

## Interface
- `XLEN`, 32, datapath width; must be a multiple of `DIV_BITS`.
- `NUM_BYPASS`, 2, number of forwarding sources, index 0 = highest priority.
- `DIV_BITS`, 1, quotient bits resolved per divider cycle; legal values are 1, 2 and 4.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `stall_in`  in  1  downstream stall; never includes `busy_out`.
- `flush_in`  in  1  squash the instruction at the input or in flight.
- `valid_in`  in  1  an instruction is present at the input.
- `muldiv_in`  in  1  the instruction is an M-extension op.
- `op_in`  in  3  funct3 encoding.
- `rs1_in`, `rs2_in`  in  5 each  source register numbers.
- `rs1_value_in`, `rs2_value_in`  in  XLEN each  register file values.
- `rd_in`  in  5  destination register.
- `rd_write_in`  in  1  the instruction writes `rd`.
- `bypass_rd_in`  in  NUM_BYPASS×5  forwarding destination registers.
- `bypass_write_in`  in  NUM_BYPASS  forwarding write enables.
- `bypass_flush_in`  in  NUM_BYPASS  the forwarding source is squashed.
- `bypass_value_in`  in  NUM_BYPASS×XLEN  forwarding values.
- `busy_out`  out  1  hazard unit must hold upstream stages.
- `valid_out`  out  1  registered result is valid.
- `rd_out`  out  5  registered destination register.
- `rd_write_out`  out  1  registered write enable.
- `result_out`  out  XLEN  registered result.

## Operation
- **Operand select (per source):** take the lowest index i with `bypass_write_in[i] && !bypass_flush_in[i] && bypass_rd_in[i]==rs && rs!=0`. Otherwise use the register file value.
- **Accept condition:** `start = state==IDLE && valid_in && muldiv_in && !flush_in && !stall_in`. On accept, latch the bypassed operands, `op`, `rd` and `rd_write`.
- **FSM states:**
  - IDLE → EXEC on `start`.
  - EXEC → IDLE when `count==0 && !stall_in`, which loads the output register.
  - Any state → IDLE on `flush_in` or `reset`.
- **Count on accept:** MUL* loads `count=0`. DIV*/REM* loads `count = XLEN/DIV_BITS`, then decrements once per non-stalled cycle. The final cycle at `count==0` applies sign correction.
- **Multiply:** compute the 2·XLEN-bit product with signedness per op.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half.
- **Divide:** restoring division on operand magnitudes, DIV_BITS per cycle.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- **Divide special cases** (full latency kept, result overridden):
  - Divisor 0: quotient = all-ones, remainder = dividend.
  - Signed MIN / −1: quotient = MIN, remainder = 0.
- **`busy_out`** = `start || (state==EXEC && count!=0)`. It drops in the completion cycle, so upstream advances on the same edge the result is written.
- **Output register** updates only when `!stall_in`:
  - Completion cycle: `valid_out=1` with the latched `rd`/`rd_write` and the result.
  - Otherwise: a bubble, with `valid_out=0` and `rd_write_out=0`.
- **Flush:** if `!stall_in`, the output register takes a bubble. Flush always aborts EXEC.
- **Reset values:**
  - State IDLE, `count=0`.
  - `valid_out=0`, `rd_write_out=0`, `rd_out=0`, `result_out=0`.
  - `busy_out=0`.

## Timing
- **MUL\* latency:** accept in cycle T; result visible in cycle T+2. `busy_out` is high in T only.
- **DIV\*/REM\* latency:** accept in T; result visible in T+N+2, with N=XLEN/DIV_BITS. `busy_out` is high in T..T+N.
- **Stall:** `stall_in` during EXEC freezes `count` and all operand/partial registers.
- **Stall in the completion cycle:** the unit holds at `count==0` with `busy_out=0`.
- **Operand sampling:** bypass inputs are sampled only in the accept cycle.
- **Back-to-back ops:** a second M op can be accepted in the cycle after completion.
- **Flush and stall together:** flush wins for the FSM; the output register holds.

## Structure
- **Shared package `rv32_muldiv_pkg`:**
  - Op constants MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - FSM state typedef {IDLE, EXEC}.
- **Sub-module `rv32_divider_step`:** combinational, DIV_BITS iterations of restoring shift-subtract on (remainder, quotient, divisor).
- **Top level:** holds the FSM, bypass muxing, multiplier and output register.

## Test plan
- **MUL:** MUL 7×−3 → `result_out` = 0xFFFFFFEB two cycles after accept; `busy_out` high for one cycle.
- **MULH:** MULH 0x80000000×0x80000000 → 0x40000000.
- **MULHSU:** MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF.
- **DIV (DIV_BITS=1):** DIV −20/3 → −6 and REM → −2; `busy_out` high 33 cycles; result in cycle T+34.
- **Divide special cases:**
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000; REM of the same → 0.
- **Bypass:** rs1=x5 with bypass[0] and bypass[1] both writing x5 (values 11, 22) → bypass[0] is used. Repeat with `bypass_flush_in[0]=1` → 22 is used. Repeat with rs1=x0 → 0.
- **Stall/flush/reset mid-operation:**
  - `stall_in` for 3 cycles mid-DIV → completion delayed exactly 3 cycles.
  - `flush_in` mid-DIV → IDLE and `valid_out=0`.
  - `reset` mid-DIV → all outputs reach reset values next cycle.
